// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker
//   Cursor engine between a PS/2 packet decoder and the VGA overlay logic.
//   It is a two-stage pipeline:
//     stage 1  sign-extends the accepted deltas, optionally inverts dy, and
//              scales both by the speed setting. It also latches the buttons
//              and the overflow flags.
//     stage 2  accumulates the scaled deltas into the absolute position, with
//              clamp or wrap edge handling. It updates the button state and
//              edge pulses, and counts dropped (overflowed) packets.
//   A software load overrides the position and discards any packet that is
//   in stage 2 during the same cycle.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   in_valid / in_ready     packet handshake (in_ready = !reset & !load)
//   dx, dy                  signed DELTA_W-bit deltas
//   ovf_x, ovf_y            packet overflow flags (the packet is dropped)
//   buttons                 {middle, right, left}
//   wrap_mode               0 = clamp at the edges, 1 = wrap around
//   speed                   delta left-shift, 0..3
//   load, load_x, load_y    force the position (clamped to the screen)
//   pos_x, pos_y            cursor position
//   pos_valid               one-cycle pulse when the position is updated
//   btn_state               registered buttons
//   btn_press, btn_release  one-cycle edge pulses
//   drop_count              saturating count of discarded packets
module mouse_cursor_tracker #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int POS_W    = 10,
  parameter int DELTA_W  = 9,
  parameter int INVERT_Y = 1,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DELTA_W-1:0] dx,
  input  logic [DELTA_W-1:0] dy,
  input  logic               ovf_x,
  input  logic               ovf_y,
  input  logic [2:0]         buttons,
  input  logic               wrap_mode,
  input  logic [1:0]         speed,
  input  logic               load,
  input  logic [POS_W-1:0]   load_x,
  input  logic [POS_W-1:0]   load_y,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic               pos_valid,
  output logic [2:0]         btn_state,
  output logic [2:0]         btn_press,
  output logic [2:0]         btn_release,
  output logic [7:0]         drop_count
);

  // Extended width: this is enough headroom for pos + (delta << 3) without
  // overflow.
  localparam int EW = POS_W + DELTA_W + 4;

  localparam logic signed [EW-1:0] SIZE_X    = EW'(SCREEN_W);
  localparam logic signed [EW-1:0] SIZE_Y    = EW'(SCREEN_H);
  localparam logic signed [EW-1:0] SIZE_X_M1 = EW'(SCREEN_W - 1);
  localparam logic signed [EW-1:0] SIZE_Y_M1 = EW'(SCREEN_H - 1);
  localparam logic [POS_W-1:0]     MAX_X     = POS_W'(SCREEN_W - 1);
  localparam logic [POS_W-1:0]     MAX_Y     = POS_W'(SCREEN_H - 1);

  // One axis of stage 2. In wrap mode the delta is first limited to
  // +/-(size-1). This keeps the sum within (-size, 2*size), so a single
  // add or subtract of size is enough to bring it back on screen.
  function automatic logic [POS_W-1:0] f_step(
    input logic [POS_W-1:0]     pos,
    input logic signed [EW-1:0] delta,
    input logic                 wrap,
    input logic signed [EW-1:0] size,
    input logic signed [EW-1:0] size_m1
  );
    logic signed [EW-1:0] v_d;
    logic signed [EW-1:0] v_sum;
    v_d = delta;
    if (wrap) begin
      if (v_d > size_m1)
        v_d = size_m1;
      else if (v_d < -size_m1)
        v_d = -size_m1;
    end
    v_sum = $signed({{(EW-POS_W){1'b0}}, pos}) + v_d;
    if (wrap) begin
      if (v_sum[EW-1])
        v_sum = v_sum + size;
      else if (v_sum >= size)
        v_sum = v_sum - size;
    end else begin
      if (v_sum[EW-1])
        v_sum = '0;
      else if (v_sum > size_m1)
        v_sum = size_m1;
    end
    return v_sum[POS_W-1:0];
  endfunction

  logic                 w_accept;
  logic signed [EW-1:0] w_dx_ext;
  logic signed [EW-1:0] w_dy_ext;
  logic signed [EW-1:0] w_dy_dir;
  logic signed [EW-1:0] w_dx_scaled;
  logic signed [EW-1:0] w_dy_scaled;
  logic [POS_W-1:0]     w_next_x;
  logic [POS_W-1:0]     w_next_y;
  logic [POS_W-1:0]     w_load_x;
  logic [POS_W-1:0]     w_load_y;

  logic                 r_s1_valid;
  logic signed [EW-1:0] r_s1_dx;
  logic signed [EW-1:0] r_s1_dy;
  logic [2:0]           r_s1_btn;
  logic                 r_s1_ovf;

  logic [POS_W-1:0]     r_pos_x;
  logic [POS_W-1:0]     r_pos_y;
  logic                 r_pos_valid;
  logic [2:0]           r_btn_state;
  logic [2:0]           r_btn_press;
  logic [2:0]           r_btn_release;
  logic [7:0]           r_drop_count;

  assign in_ready = ~reset & ~load;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_dx_ext    = {{(EW-DELTA_W){dx[DELTA_W-1]}}, dx};
    w_dy_ext    = {{(EW-DELTA_W){dy[DELTA_W-1]}}, dy};
    w_dy_dir    = (INVERT_Y != 0) ? -w_dy_ext : w_dy_ext;
    w_dx_scaled = w_dx_ext << speed;
    w_dy_scaled = w_dy_dir << speed;
  end

  always_comb begin
    w_next_x = f_step(r_pos_x, r_s1_dx, wrap_mode, SIZE_X, SIZE_X_M1);
    w_next_y = f_step(r_pos_y, r_s1_dy, wrap_mode, SIZE_Y, SIZE_Y_M1);
    w_load_x = (load_x > MAX_X) ? MAX_X : load_x;
    w_load_y = (load_y > MAX_Y) ? MAX_Y : load_y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_dx       <= '0;
      r_s1_dy       <= '0;
      r_s1_btn      <= '0;
      r_s1_ovf      <= 1'b0;
      r_pos_x       <= POS_W'(INIT_X);
      r_pos_y       <= POS_W'(INIT_Y);
      r_pos_valid   <= 1'b0;
      r_btn_state   <= '0;
      r_btn_press   <= '0;
      r_btn_release <= '0;
      r_drop_count  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_dx  <= w_dx_scaled;
        r_s1_dy  <= w_dy_scaled;
        r_s1_btn <= buttons;
        r_s1_ovf <= ovf_x | ovf_y;
      end

      r_pos_valid   <= 1'b0;
      r_btn_press   <= '0;
      r_btn_release <= '0;

      // A load takes priority. The packet in stage 2 is dropped without
      // touching the buttons or the drop counter.
      if (load) begin
        r_pos_x     <= w_load_x;
        r_pos_y     <= w_load_y;
        r_pos_valid <= 1'b1;
      end else if (r_s1_valid) begin
        r_btn_state   <= r_s1_btn;
        r_btn_press   <= r_s1_btn & ~r_btn_state;
        r_btn_release <= ~r_s1_btn & r_btn_state;
        if (r_s1_ovf) begin
          if (r_drop_count != 8'hFF)
            r_drop_count <= r_drop_count + 8'd1;
        end else begin
          r_pos_x     <= w_next_x;
          r_pos_y     <= w_next_y;
          r_pos_valid <= 1'b1;
        end
      end
    end
  end

  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign pos_valid   = r_pos_valid;
  assign btn_state   = r_btn_state;
  assign btn_press   = r_btn_press;
  assign btn_release = r_btn_release;
  assign drop_count  = r_drop_count;

endmodule
